// File: rtl/holy_core_pkg.sv
// holy_core_pkg: shared types and constants for the AXI-Lite bridge.
// Holds the bridge FSM state enum and the AXI OKAY response code.
package holy_core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } axil_bridge_state_t;

  localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bus bundle with AW/W/B/AR/R channels.
// master drives AW/W/AR payload+valid and B/R ready; slave the reverse.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

endinterface

// File: rtl/mem_req_to_axi_lite_bridge.sv
// mem_req_to_axi_lite_bridge: one-outstanding mem req -> AXI4-Lite master.
// Ports: clk/rst; req_i/add_i/we_i/wdata_i/be_i request in; gnt_o and
// r_valid_o/r_rdata_o/r_err_o completion out; out_if_axil_m AXI master;
// bridge_state exposes the FSM state for debug.
module mem_req_to_axi_lite_bridge
  import holy_core_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int STRB_W        = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic [ADDR_W-1:0]  add_i,
  input  logic               we_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [STRB_W-1:0]  be_i,
  output logic               gnt_o,
  output logic               r_valid_o,
  output logic [DATA_W-1:0]  r_rdata_o,
  output logic               r_err_o,
  axi_lite_if.master         out_if_axil_m,
  output axil_bridge_state_t bridge_state
);

  localparam int OFF_W = $clog2(STRB_W);
  localparam int CNT_W =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  axil_bridge_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] be_q, be_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              r_valid_q, r_valid_d;
  logic              r_err_q, r_err_d;
  logic [DATA_W-1:0] r_rdata_q, r_rdata_d;

  logic              gnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              tmo_hit;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Fires on the cycle whose edge brings the wait count to the limit.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    r_valid_d = 1'b0;
    r_err_d   = r_err_q;
    r_rdata_d = r_rdata_q;
    gnt       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          gnt       = 1'b1;
          addr_d    = {add_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d   = wdata_i;
          be_d      = be_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          // A write with no enabled bytes has nothing to put on the bus.
          if (we_i && (be_i == '0)) begin
            r_valid_d = 1'b1;
            r_err_d   = 1'b0;
          end else if (we_i) begin
            state_d = WR_ADDR_DATA;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end

      WR_ADDR_DATA: begin
        aw_done_d = aw_done_q | out_if_axil_m.awready;
        w_done_d  = w_done_q | out_if_axil_m.wready;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
          cnt_d   = '0;
        end
      end

      WR_RESP: begin
        cnt_d = cnt_inc;
        if (out_if_axil_m.bvalid) begin
          r_valid_d = 1'b1;
          r_err_d   = (out_if_axil_m.bresp != OKAY);
          state_d   = IDLE;
        end else if (tmo_hit) begin
          r_valid_d = 1'b1;
          r_err_d   = 1'b1;
          state_d   = IDLE;
        end
      end

      RD_ADDR: begin
        if (out_if_axil_m.arready) begin
          state_d = RD_DATA;
          cnt_d   = '0;
        end
      end

      RD_DATA: begin
        cnt_d = cnt_inc;
        if (out_if_axil_m.rvalid) begin
          r_valid_d = 1'b1;
          r_rdata_d = out_if_axil_m.rdata;
          r_err_d   = (out_if_axil_m.rresp != OKAY);
          state_d   = IDLE;
        end else if (tmo_hit) begin
          r_valid_d = 1'b1;
          r_err_d   = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      r_err_q   <= r_err_d;
      r_rdata_q <= r_rdata_d;
    end
  end

  // Bus-facing controls are forced low while rst is held, so nothing
  // leaks out before the first reset edge has settled the state.
  assign out_if_axil_m.awvalid =
    !rst && (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign out_if_axil_m.awaddr  = addr_q;
  assign out_if_axil_m.awprot  = 3'b000;

  assign out_if_axil_m.wvalid  =
    !rst && (state_q == WR_ADDR_DATA) && !w_done_q;
  assign out_if_axil_m.wdata   = wdata_q;
  assign out_if_axil_m.wstrb   = be_q;

  // Readies stay up in IDLE to swallow responses that arrive too late.
  assign out_if_axil_m.bready  =
    !rst && ((state_q == WR_RESP) || (state_q == IDLE));

  assign out_if_axil_m.arvalid = !rst && (state_q == RD_ADDR);
  assign out_if_axil_m.araddr  = addr_q;
  assign out_if_axil_m.arprot  = 3'b000;

  assign out_if_axil_m.rready  =
    !rst && ((state_q == RD_DATA) || (state_q == IDLE));

  assign gnt_o        = gnt && !rst;
  assign r_valid_o    = r_valid_q;
  assign r_err_o      = r_err_q;
  assign r_rdata_o    = r_rdata_q;
  assign bridge_state = state_q;

endmodule

// File: doc/mem_req_to_axi_lite_bridge.md
MEM_REQ_TO_AXI_LITE_BRIDGE -- requirements
Module: mem_req_to_axi_lite_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: request and AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width, 32 or 64 only; STRB_W = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: response-wait limit; 0 disables the limit.
REQ-004 SHALL have ports `clk` (in, 1), the single clock, and `rst` (in, 1), a synchronous, active-high reset.
REQ-005 SHALL have ports `req_i` (in, 1) request valid; `add_i` (in, ADDR_W) byte address; `we_i` (in, 1) write; `wdata_i` (in, DATA_W); `be_i` (in, STRB_W).
REQ-006 SHALL have ports `gnt_o` (out, 1) request accepted; `r_valid_o` (out, 1) completion; `r_rdata_o` (out, DATA_W); `r_err_o` (out, 1) completion error.
REQ-007 SHALL have `out_if_axil_m` (axi_lite_if.master), carrying all AW/W/B/AR/R channel signals at ADDR_W and DATA_W.
REQ-008 SHALL have `bridge_state` (out, axil_bridge_state_t): current state, for debug.

Function
REQ-009 SHALL use FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
REQ-010 In IDLE with req_i=1, SHALL pulse gnt_o for 1 cycle and capture add_i, we_i, wdata_i and be_i into registers.
- Next state: WR_ADDR_DATA if we_i, else RD_ADDR.
- The requester need not hold its inputs after gnt_o.
REQ-011 A write with be_i==0 SHALL be granted and completed 1 cycle later with r_valid_o=1 and r_err_o=0, with no AXI traffic.
REQ-012 SHALL align awaddr and araddr down to a STRB_W boundary; wstrb = captured be; wdata = captured data.
REQ-013 In WR_ADDR_DATA, SHALL assert awvalid and wvalid together.
- Handshake tracking: separate aw_done and w_done flags.
- awvalid drops after its own handshake; wvalid drops after its own handshake.
- Enter WR_RESP once both are done, including when both complete in the same cycle.
REQ-014 In WR_RESP, SHALL assert bready; on bvalid, pulse r_valid_o and set r_err_o = (bresp != 2'b00), then return to IDLE.
REQ-015 In RD_ADDR, SHALL hold arvalid until arready, then enter RD_DATA.
REQ-016 In RD_DATA, SHALL assert rready; on rvalid, pulse r_valid_o, register rdata into r_rdata_o, set r_err_o = (rresp != 2'b00), then return to IDLE.
REQ-017 SHALL hold r_rdata_o stable between read completions; write completions SHALL NOT alter it.
REQ-018 Each valid SHALL stay asserted until its handshake; the timeout SHALL NOT drop a valid.
REQ-019 A cycle counter SHALL clear on entry to WR_RESP or RD_DATA and increment each cycle in those states.
- When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: pulse r_valid_o with r_err_o=1, r_rdata_o unchanged, and go to IDLE.
REQ-020 In IDLE, SHALL hold bready=1 and rready=1 so that late responses are drained silently (no r_valid_o).
REQ-021 gnt_o SHALL NOT assert outside IDLE, so at most one transaction is outstanding.
REQ-022 Back-to-back operation: a req_i present in the cycle after completion SHALL be granted that cycle.

Reset
REQ-023 While rst=1, SHALL set state=IDLE, all AXI valids and readies=0, gnt_o=0, r_valid_o=0, r_err_o=0, r_rdata_o=0, counter=0, and done flags=0.
REQ-024 Reset asserted mid-transaction SHALL abandon it with no completion pulse; the first post-reset cycle SHALL be IDLE.

Structure
REQ-025 axil_bridge_state_t SHALL be defined in holy_core_pkg.
REQ-026 The AXI response code constant OKAY = 2'b00 SHALL be defined in holy_core_pkg.
REQ-027 SHALL have no sub-module; the FSM, capture registers and timeout counter SHALL be inline.

Verification
REQ-028 Read: read of 0x1000 with slave rdata=0xDEADBEEF after 3 cycles -> gnt_o 1 cycle, then r_valid_o=1, r_rdata_o=0xDEADBEEF, r_err_o=0.
REQ-029 Write handshake order: write 0x0000_0040, be=4'b0011; W handshakes 2 cycles before AW -> one AW and one W beat, wstrb=0011, awaddr=0x40, single r_valid_o.
REQ-030 Write with address fixed up: 0x1006, DATA_W=64, bresp=2'b10 -> awaddr=0x1000, r_err_o=1.
REQ-031 Timeout: TIMEOUT_CYCLES=8, slave never sends rvalid -> r_valid_o with r_err_o=1 exactly 8 cycles after RD_DATA entry; a late rvalid is drained with no completion.
REQ-032 Edge cases: a write with be=0 completes with no AXI activity; rst pulsed during WR_RESP -> IDLE, no r_valid_o, and the next request proceeds normally.
